// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Generates stage enables/flushes for load-use, redirect and memory wait.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_MemRead,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_bubble,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    state_e            state_q;
    state_e            state_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;
    logic              mem_err_q;
    logic              mem_err_d;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d;

    logic lu_hazard;
    logic mem_stall;
    logic freeze;
    logic lu_stall;
    logic redirect_take;

    assign lu_hazard = ex_MemRead && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        mem_err_d     = mem_err_q;
        freeze        = 1'b0;
        lu_stall      = 1'b0;
        redirect_take = 1'b0;
        unique case (state_q)
            RUN: begin
                priority case (1'b1)
                    mem_stall: begin
                        freeze   = 1'b1;
                        state_d  = MEM_WAIT;
                        to_cnt_d = TO_ONE;
                    end
                    ex_redirect: redirect_take = 1'b1;
                    lu_hazard:   lu_stall      = 1'b1;
                    default: ;
                endcase
            end
            MEM_WAIT: begin
                // A completing access releases the pipe this very cycle;
                // EX events are only looked at once back in RUN.
                if (mem_ready) begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else begin
                    freeze = 1'b1;
                    if (to_cnt_q == TO_LIMIT) begin
                        state_d   = ERROR;
                        mem_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end
            end
            ERROR: begin
                freeze    = 1'b1;
                mem_err_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en        = rst && !freeze && !lu_stall;
        ifid_en      = rst && !freeze && !lu_stall;
        ifid_flush   = !rst || redirect_take;
        idex_en      = rst && !freeze;
        idex_flush   = !rst || redirect_take || lu_stall;
        exmem_en     = rst && !freeze;
        memwb_bubble = !rst || freeze;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != PERF_MAX) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end
        if (redirect_take && flush_cnt_q != PERF_MAX) begin
            flush_cnt_d = flush_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: reference model plus directed vectors.
// Drives a default instance and a 4-bit-counter instance in parallel.
module tb_hazard_ctrl;

    localparam int TO = 15;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic [4:0] id_rs1      = '0;
    logic [4:0] id_rs2      = '0;
    logic [4:0] ex_rd       = '0;
    logic       ex_MemRead  = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       mem_req     = 1'b0;
    logic       mem_ready   = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_en;
    logic        idex_flush, exmem_en, memwb_bubble, mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en;
    logic        s_idex_flush, s_exmem_en, s_memwb_bubble, s_mem_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    // model state: waiting on memory, low-ready run length, error, counts
    bit m_wait  = 1'b0;
    bit m_err   = 1'b0;
    int m_low   = 0;
    int m_stall = 0;
    int m_flush = 0;

    // row bit order: pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, bubble
    localparam logic [6:0] R_DEF = 7'b1101010;
    localparam logic [6:0] R_FRZ = 7'b0000001;
    localparam logic [6:0] R_RST = 7'b0010101;
    localparam logic [6:0] R_RED = 7'b1111110;
    localparam logic [6:0] R_LU  = 7'b0001110;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4), .PERF_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4), .PERF_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_flush(s_idex_flush),
        .exmem_en(s_exmem_en), .memwb_bubble(s_memwb_bubble),
        .mem_err(s_mem_err), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit frozen_now();
        if (m_err) return 1'b1;
        if (m_wait) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    function automatic bit redirect_applied();
        return rst && !m_wait && !m_err && !frozen_now() && ex_redirect;
    endfunction

    function automatic logic [6:0] exp_row();
        bit hit;
        hit = ex_MemRead && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        if (!rst) return R_RST;
        if (frozen_now()) return R_FRZ;
        if (m_wait) return R_DEF;
        if (ex_redirect) return R_RED;
        if (hit) return R_LU;
        return R_DEF;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_wait  <= 1'b0;
            m_err   <= 1'b0;
            m_low   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if ((exp_row() & 7'b1000000) == 7'd0) m_stall <= m_stall + 1;
            if (redirect_applied()) m_flush <= m_flush + 1;
            if (!m_err) begin
                if (m_wait) begin
                    if (mem_ready) begin
                        m_wait <= 1'b0;
                        m_low  <= 0;
                    end else begin
                        m_low <= m_low + 1;
                        if (m_low + 1 > TO) m_err <= 1'b1;
                    end
                end else if (mem_req && !mem_ready) begin
                    m_wait <= 1'b1;
                    m_low  <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("row", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, memwb_bubble}, exp_row());
        chk("row_sat", {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en,
                        s_idex_flush, s_exmem_en, s_memwb_bubble}, exp_row());
        chk("mem_err", mem_err, m_err);
        chk("mem_err_sat", s_mem_err, m_err);
        chk("stall_cnt", stall_cnt, sat(m_stall, 16));
        chk("flush_cnt", flush_cnt, sat(m_flush, 16));
        chk("stall_cnt_sat", s_stall_cnt, sat(m_stall, 4));
        chk("flush_cnt_sat", s_flush_cnt, sat(m_flush, 4));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rst         = 1'b1;
        id_rs1      = '0;
        id_rs2      = '0;
        ex_rd       = '0;
        ex_MemRead  = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2);
        ex_MemRead = 1'b1;
        ex_rd      = rd;
        id_rs1     = r1;
        id_rs2     = r2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mid();
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_flushes", {ifid_flush, idex_flush, memwb_bubble}, 3'b111);
        tick();
        idle();
        mid();
        chk("default_row", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
        chk("rst_counts", {stall_cnt, flush_cnt}, 32'd0);

        tick();
        set_lu(5'd5, 5'd0, 5'd5);
        mid();
        chk("lu_row", {pc_en, ifid_en, idex_flush}, 3'b001);
        tick();
        idle();
        mid();
        chk("lu_one_cycle", pc_en, 1'b1);
        chk("lu_stall_cnt", stall_cnt, 16'd1);

        tick();
        set_lu(5'd0, 5'd0, 5'd3);
        mid();
        chk("x0_no_stall", pc_en, 1'b1);
        tick();
        set_lu(5'd7, 5'd6, 5'd8);
        mid();
        chk("nodep_no_stall", pc_en, 1'b1);
        tick();
        idle();
        mid();
        chk("nodep_stall_cnt", stall_cnt, 16'd1);

        tick();
        set_lu(5'd5, 5'd5, 5'd0);
        ex_redirect = 1'b1;
        mid();
        chk("red_lu_row", {pc_en, ifid_flush, idex_flush}, 3'b111);
        tick();
        idle();
        mid();
        chk("red_flush_cnt", flush_cnt, 16'd1);
        chk("red_stall_cnt", stall_cnt, 16'd1);

        tick();
        mem_req     = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("memwait_row", {pc_en, ifid_en, idex_en, exmem_en,
                                memwb_bubble}, 5'b00001);
            tick();
        end
        mem_ready = 1'b1;
        mid();
        chk("mem_release", {pc_en, ifid_flush, memwb_bubble}, 3'b100);
        tick();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        mid();
        chk("held_redirect", {pc_en, ifid_flush, idex_flush}, 3'b111);
        tick();
        idle();
        mid();
        chk("memwait_stall_cnt", stall_cnt, 16'd4);
        chk("memwait_flush_cnt", flush_cnt, 16'd2);

        tick();
        mem_req     = 1'b1;
        mem_ready   = 1'b1;
        ex_redirect = 1'b1;
        mid();
        chk("ready_redirect", ifid_flush, 1'b1);
        tick();
        idle();
        mid();
        chk("ready_flush_cnt", flush_cnt, 16'd3);

        mem_req = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            mid();
            if (mem_err) begin
                n = i;
                break;
            end
        end
        chk("timeout_cycles", n, 16);
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        tick();
        mid();
        chk("err_sticky", {mem_err, pc_en, memwb_bubble}, 3'b101);
        chk("err_sat_cnt", s_stall_cnt, 4'd15);
        rst = 1'b0;
        #1;
        chk("rst_row_err", {pc_en, ifid_flush, idex_flush, memwb_bubble},
            4'b0111);
        tick();
        idle();
        mid();
        chk("err_cleared", {mem_err, pc_en, ifid_flush}, 3'b010);
        chk("err_rst_cnt", stall_cnt, 16'd0);

        set_lu(5'd9, 5'd9, 5'd1);
        repeat (20) tick();
        idle();
        mid();
        chk("sat_stall_4b", s_stall_cnt, 4'd15);
        chk("sat_stall_16b", stall_cnt, 16'd20);

        mem_req = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_wait", {ifid_flush, idex_flush, memwb_bubble, pc_en,
                            exmem_en}, 5'b11100);
        tick();
        idle();
        mid();
        chk("rst_wait_cnts", {stall_cnt, flush_cnt}, 32'd0);
        chk("rst_wait_run", {pc_en, memwb_bubble}, 2'b10);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
